// File: rtl/arm_pkg.sv
// Shared definitions for the condition-flag path.
//   FLAG_*     : bit positions of N/Z/C/V inside a 4-bit NZCV vector
//   op_class_e : execute-stage instruction class for flag generation
//   cond_e     : condition codes, shared with the issue-stage condition checker
package arm_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    OPC_ARITH = 2'd0,
    OPC_LOGIC = 2'd1,
    OPC_MUL   = 2'd2,
    OPC_NONE  = 2'd3
  } op_class_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

endpackage

// File: rtl/nzcv_flag_unit_if.sv
// Execute-stage to flag-unit bus.
//   master : pipeline side, drives instruction/ALU info and stall/flush, reads flags
//   slave  : flag unit, reads instruction/ALU info, drives nzcv_arch/nzcv_fwd/flags_pending
interface nzcv_flag_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                valid;
  logic                s_bit;
  logic                cond_pass;
  arm_pkg::op_class_e  op_class;
  logic [WIDTH-1:0]    alu_result;
  logic                alu_carry;
  logic                alu_overflow;
  logic                shift_carry;
  logic                msr_we;
  logic [3:0]          msr_data;
  logic                stall;
  logic                flush;
  logic [3:0]          nzcv_arch;
  logic [3:0]          nzcv_fwd;
  logic                flags_pending;

  modport master (
    output valid, s_bit, cond_pass, op_class, alu_result, alu_carry, alu_overflow,
           shift_carry, msr_we, msr_data, stall, flush,
    input  nzcv_arch, nzcv_fwd, flags_pending
  );

  modport slave (
    input  valid, s_bit, cond_pass, op_class, alu_result, alu_carry, alu_overflow,
           shift_carry, msr_we, msr_data, stall, flush,
    output nzcv_arch, nzcv_fwd, flags_pending
  );
endinterface

// File: rtl/nzcv_calc.sv
// Combinational candidate-flag generator.
//   op_class, alu_result, alu_carry, alu_overflow, shift_carry : ALU outputs
//   msr_we, msr_data : direct flag write (takes priority over ALU-derived flags)
//   base             : value supplying preserved bits (the forwarded flags)
//   cand             : candidate NZCV, [3]=N [2]=Z [1]=C [0]=V
module nzcv_calc
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_class_e        op_class,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             shift_carry,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  input  logic [3:0]       base,
  output logic [3:0]       cand
);

  logic res_neg;
  logic res_zero;

  assign res_neg  = alu_result[WIDTH-1];
  assign res_zero = (alu_result == '0);

  always_comb begin
    cand = base;
    if (msr_we) begin
      cand = msr_data;
    end else begin
      case (op_class)
        OPC_ARITH: begin
          cand[FLAG_N] = res_neg;
          cand[FLAG_Z] = res_zero;
          cand[FLAG_C] = alu_carry;
          cand[FLAG_V] = alu_overflow;
        end
        OPC_LOGIC: begin
          cand[FLAG_N] = res_neg;
          cand[FLAG_Z] = res_zero;
          cand[FLAG_C] = shift_carry;
        end
        OPC_MUL: begin
          cand[FLAG_N] = res_neg;
          cand[FLAG_Z] = res_zero;
        end
        default: cand = base;
      endcase
    end
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV producer: captures candidate flags into a one-entry pending register and
// commits them to the architectural register on the following unstalled cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : execute-stage inputs, stall/flush, and flag outputs
//                (nzcv_arch, nzcv_fwd = youngest pending-or-committed, flags_pending)
module nzcv_flag_unit
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  nzcv_flag_unit_if.slave  bus
);

  logic [3:0] arch_q, arch_d;
  logic [3:0] pend_data_q, pend_data_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] fwd;
  logic [3:0] cand;
  logic       capture;

  // Preserved bits come from the forwarded view so back-to-back setters chain.
  assign fwd = pend_valid_q ? pend_data_q : arch_q;

  nzcv_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op_class     (bus.op_class),
    .alu_result   (bus.alu_result),
    .alu_carry    (bus.alu_carry),
    .alu_overflow (bus.alu_overflow),
    .shift_carry  (bus.shift_carry),
    .msr_we       (bus.msr_we),
    .msr_data     (bus.msr_data),
    .base         (fwd),
    .cand         (cand)
  );

  assign capture = bus.valid & bus.cond_pass & ~bus.stall & ~bus.flush &
                   (bus.msr_we | (bus.s_bit & (bus.op_class != OPC_NONE)));

  always_comb begin
    arch_d       = arch_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    if (bus.flush) begin
      // Squash: drop the pending entry without committing it.
      pend_valid_d = 1'b0;
    end else if (!bus.stall) begin
      if (pend_valid_q) begin
        arch_d = pend_data_q;
      end
      pend_valid_d = capture;
      if (capture) begin
        pend_data_d = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arch_q       <= 4'b0000;
      pend_data_q  <= 4'b0000;
      pend_valid_q <= 1'b0;
    end else begin
      arch_q       <= arch_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.nzcv_arch     = arch_q;
  assign bus.nzcv_fwd      = fwd;
  assign bus.flags_pending = pend_valid_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Self-checking bench for nzcv_flag_unit: table of one-cycle vectors with expected
// post-edge outputs, then a hand-written back-to-back sequence.
module tb_nzcv_flag_unit;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  nzcv_flag_unit_if #(.WIDTH(32)) bus ();

  nzcv_flag_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n, valid, s_bit, cond_pass;
    logic [1:0]  opc;
    logic [31:0] res;
    logic        c, v, sc, msr_we;
    logic [3:0]  msr_data;
    logic        stall, flush;
    logic [3:0]  e_arch, e_fwd;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rn, logic vl, logic s, logic cp,
                              logic [1:0] opc, logic [31:0] res, logic c, logic v,
                              logic sc, logic mw, logic [3:0] md, logic st, logic fl,
                              logic [3:0] ea, logic [3:0] ef, logic ep);
    vec_t r;
    r.name = name; r.rst_n = rn; r.valid = vl; r.s_bit = s; r.cond_pass = cp;
    r.opc = opc; r.res = res; r.c = c; r.v = v; r.sc = sc; r.msr_we = mw;
    r.msr_data = md; r.stall = st; r.flush = fl;
    r.e_arch = ea; r.e_fwd = ef; r.e_pend = ep;
    return r;
  endfunction

  task automatic apply(input vec_t r);
    rst_n            = r.rst_n;
    bus.valid        = r.valid;
    bus.s_bit        = r.s_bit;
    bus.cond_pass    = r.cond_pass;
    bus.op_class     = op_class_e'(r.opc);
    bus.alu_result   = r.res;
    bus.alu_carry    = r.c;
    bus.alu_overflow = r.v;
    bus.shift_carry  = r.sc;
    bus.msr_we       = r.msr_we;
    bus.msr_data     = r.msr_data;
    bus.stall        = r.stall;
    bus.flush        = r.flush;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic vec_t idle(string name, logic [3:0] ea, logic [3:0] ef, logic ep);
    return mk(name, 1, 0, 0, 0, 2'd3, 32'h0, 0, 0, 0, 0, 4'h0, 0, 0, ea, ef, ep);
  endfunction

  function automatic vec_t msr(string name, logic [3:0] md, logic [3:0] ea,
                               logic [3:0] ef, logic ep);
    return mk(name, 1, 1, 0, 1, 2'd3, 32'h0, 0, 0, 0, 1, md, 0, 0, ea, ef, ep);
  endfunction

  logic [3:0] tp [4];

  initial begin
    //              name            rn vl s cp opc  res            c v sc mw md    st fl  arch  fwd   pend
    vecs.push_back(mk("reset",      0, 1, 0, 1, 2'd3, 32'h0,        0, 0, 0, 1, 4'hF, 1, 0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("subs",       1, 1, 1, 1, 2'd0, 32'h0,        1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h6, 1));
    vecs.push_back(idle("subs_commit", 4'h6, 4'h6, 0));
    vecs.push_back(msr("msr_0001", 4'h1, 4'h6, 4'h1, 1));
    vecs.push_back(idle("msr_0001_commit", 4'h1, 4'h1, 0));
    vecs.push_back(mk("ands",       1, 1, 1, 1, 2'd1, 32'h8000_0000, 1, 0, 0, 0, 4'h0, 0, 0, 4'h1, 4'h9, 1));
    vecs.push_back(idle("ands_commit", 4'h9, 4'h9, 0));
    vecs.push_back(mk("adds",       1, 1, 1, 1, 2'd0, 32'h5,        0, 0, 0, 0, 4'h0, 0, 0, 4'h9, 4'h0, 1));
    vecs.push_back(mk("muls_b2b",   1, 1, 1, 1, 2'd2, 32'h0,        1, 1, 1, 0, 4'h0, 0, 0, 4'h0, 4'h4, 1));
    vecs.push_back(idle("muls_commit", 4'h4, 4'h4, 0));
    vecs.push_back(msr("msr_1000", 4'h8, 4'h4, 4'h8, 1));
    vecs.push_back(mk("stall_1",    1, 1, 0, 1, 2'd3, 32'h0,        0, 0, 0, 1, 4'h3, 1, 0, 4'h4, 4'h8, 1));
    vecs.push_back(mk("stall_2",    1, 1, 0, 1, 2'd3, 32'h0,        0, 0, 0, 1, 4'h3, 1, 0, 4'h4, 4'h8, 1));
    vecs.push_back(mk("flush",      1, 1, 0, 1, 2'd3, 32'h0,        0, 0, 0, 1, 4'h7, 0, 1, 4'h4, 4'h4, 0));
    vecs.push_back(mk("cond_fail",  1, 1, 1, 0, 2'd0, 32'h0,        1, 1, 0, 0, 4'h0, 0, 0, 4'h4, 4'h4, 0));
    vecs.push_back(mk("no_flag_op", 1, 1, 1, 1, 2'd3, 32'h0,        1, 1, 1, 0, 4'h0, 0, 0, 4'h4, 4'h4, 0));
    vecs.push_back(msr("msr_1111", 4'hF, 4'h4, 4'hF, 1));
    vecs.push_back(idle("msr_1111_commit", 4'hF, 4'hF, 0));
    vecs.push_back(msr("msr_0010", 4'h2, 4'hF, 4'h2, 1));
    vecs.push_back(mk("cf_commit",  1, 1, 0, 0, 2'd3, 32'h0,        0, 0, 0, 1, 4'hF, 0, 0, 4'h2, 4'h2, 0));
    vecs.push_back(msr("msr_1010", 4'hA, 4'h2, 4'hA, 1));
    vecs.push_back(mk("reset_mid",  0, 1, 0, 1, 2'd3, 32'h0,        0, 0, 0, 1, 4'h5, 1, 1, 4'h0, 4'h0, 0));
    vecs.push_back(msr("msr_1100", 4'hC, 4'h0, 4'hC, 1));
    vecs.push_back(mk("stall_hold", 1, 0, 0, 0, 2'd3, 32'h0,        0, 0, 0, 0, 4'h0, 1, 0, 4'h0, 4'hC, 1));
    vecs.push_back(idle("late_commit", 4'hC, 4'hC, 0));
    vecs.push_back(mk("ands_sc",    1, 1, 1, 1, 2'd1, 32'h1,        0, 1, 1, 0, 4'h0, 0, 0, 4'hC, 4'h2, 1));
    vecs.push_back(idle("ands_sc_commit", 4'h2, 4'h2, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check({vecs[i].name, "/arch"}, bus.nzcv_arch, vecs[i].e_arch);
      check({vecs[i].name, "/fwd"}, bus.nzcv_fwd, vecs[i].e_fwd);
      check({vecs[i].name, "/pend"}, {3'b000, bus.flags_pending}, {3'b000, vecs[i].e_pend});
    end

    // Sustained one-per-cycle msr writes; arch lags fwd by exactly one cycle.
    tp[0] = 4'h3; tp[1] = 4'h5; tp[2] = 4'h9; tp[3] = 4'h6;
    apply(msr("tp", tp[0], 4'h0, 4'h0, 0));
    #2;
    // Inputs changed mid-cycle must not reach the outputs before the edge.
    check("no_comb_fwd", bus.nzcv_fwd, 4'h2);
    check("no_comb_pend", {3'b000, bus.flags_pending}, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tp%0d/fwd", k), bus.nzcv_fwd, tp[k]);
      check($sformatf("tp%0d/pend", k), {3'b000, bus.flags_pending}, 4'h1);
      check($sformatf("tp%0d/arch", k), bus.nzcv_arch, (k == 0) ? 4'h2 : tp[(k == 0) ? 0 : k - 1]);
      if (k < 3) apply(msr("tp", tp[k + 1], 4'h0, 4'h0, 0));
    end
    apply(idle("tp_end", 4'h0, 4'h0, 0));
    @(posedge clk);
    #1;
    check("tp_final/arch", bus.nzcv_arch, 4'h6);
    check("tp_final/pend", {3'b000, bus.flags_pending}, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
